// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory between the CPU port and the UART loader.
// Request-to-ready takes WAIT+2 cycles; a requester holds its request until its one-cycle ready pulse.
module mem_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int WAIT = 1
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    gnt
);

  if (WAIT < 1 || WAIT > 4) begin : g_bad_wait
    $error("mem_arbiter: WAIT must be in 1..4");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] WLAST = 2'(WAIT - 1);

  state_t     state;
  logic [1:0] wcnt;
  logic [1:0] last_gnt;
  logic       own_we;
  logic       we_arm;
  logic       any_req;
  logic       pick_ldr;
  logic       pick_we;

  // Loader wins only when the CPU is idle or the CPU had the previous grant.
  always_comb begin
    any_req  = cpu_req | ldr_req;
    pick_ldr = ldr_req & (~cpu_req | last_gnt[0]);
    pick_we  = pick_ldr ? ldr_we : cpu_we;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_en) begin
      if (gnt[1]) begin
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
      end else begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
    end
  end

  // The strobe is armed from registered state; a reset landing on the write edge kills it.
  assign mem_we = we_arm & ~CLR;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= IDLE;
      wcnt      <= '0;
      last_gnt  <= 2'b10;
      gnt       <= '0;
      own_we    <= 1'b0;
      we_arm    <= 1'b0;
      mem_en    <= 1'b0;
      cpu_ready <= 1'b0;
      ldr_ready <= 1'b0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= ACCESS;
            gnt      <= pick_ldr ? 2'b10 : 2'b01;
            last_gnt <= pick_ldr ? 2'b10 : 2'b01;
            wcnt     <= '0;
            mem_en   <= 1'b1;
            own_we   <= pick_we;
            we_arm   <= pick_we & (WLAST == 2'd0);
          end
        end
        ACCESS: begin
          if (wcnt == WLAST) begin
            state  <= DONE;
            mem_en <= 1'b0;
            we_arm <= 1'b0;
            if (gnt[0]) begin
              cpu_ready <= 1'b1;
              if (!own_we) cpu_rdata <= mem_rdata;
            end
            if (gnt[1]) begin
              ldr_ready <= 1'b1;
              if (!own_we) ldr_rdata <= mem_rdata;
            end
          end else begin
            wcnt   <= wcnt + 2'd1;
            we_arm <= own_we & ((wcnt + 2'd1) == WLAST);
          end
        end
        DONE: begin
          state     <= IDLE;
          gnt       <= '0;
          cpu_ready <= 1'b0;
          ldr_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_gnt_onehot: assert property (@(posedge CLK) disable iff (CLR) !(gnt[0] && gnt[1]));
  a_ready_excl: assert property (@(posedge CLK) disable iff (CLR) !(cpu_ready && ldr_ready));
  a_we_in_access: assert property (@(posedge CLK) disable iff (CLR) mem_we |-> mem_en);

endmodule
